// File: rtl/lrf_dummy_stream.sv
// lrf_dummy_stream: stand-in for the LRF fusion datapath.
// Passes packed 8-bit pixel beats from an AXI4-Stream slave to an AXI4-Stream
// master through a 2-entry skid buffer. It keeps output-side beat and frame
// counters, and the output TLAST comes from the beat counter.
// Optional feature, enabled by defining LRF_DUMMY_FRAME_TAG_EN: the MSB byte of
// beat 0 of each output frame carries the frame index (0..N_FUSE_COUNT-1).
module lrf_dummy_stream #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int N_FUSE_COUNT    = 4
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_aresetn,
  input  logic [8*PIXELS_PER_BEAT-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [8*PIXELS_PER_BEAT-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);

  localparam int DW  = 8 * PIXELS_PER_BEAT;
  localparam int WPF = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int BW  = $clog2(WPF + 1);
  localparam int FW  = $clog2(N_FUSE_COUNT + 1);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(WPF - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(N_FUSE_COUNT - 1);

  // Framing is derived from the beat counter, so the input TLAST is not used.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic          out_last_q,  out_last_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q,  skid_data_d;
  logic          ready_q,     ready_d;
  logic [BW-1:0] beat_q,      beat_d;
  logic [FW-1:0] frame_q,     frame_d;
  logic          s_hs, m_hs;
  logic [DW-1:0] load_data;

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;

  // Next-state logic for the skid buffer and the beat and frame counters.
  always_comb begin
    s_hs         = s_axis_tvalid & ready_q;
    m_hs         = out_valid_q & m_axis_tready;
    beat_d       = beat_q;
    frame_d      = frame_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    // beat_d is the index of the beat at the head of the buffer after this edge.
    if (m_hs) begin
      if (beat_q == BEAT_LAST) begin
        beat_d  = '0;
        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FW'(1);
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    // Any beat that moves into the output register becomes the head beat.
    // The tag is applied at that point, so a stalled beat is never modified again.
    load_data = skid_valid_q ? skid_data_q : s_axis_tdata;
`ifdef LRF_DUMMY_FRAME_TAG_EN
    if (beat_d == '0) begin
      load_data[DW-1 -: 8] = 8'(frame_d);
    end
`endif

    if (!out_valid_q || m_hs) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = load_data;
        skid_valid_d = s_hs;
        if (s_hs) begin
          skid_data_d = s_axis_tdata;
        end
      end else begin
        out_valid_d = s_hs;
        if (s_hs) begin
          out_data_d = load_data;
        end
      end
    end else if (s_hs) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
    end

    out_last_d = out_valid_d && (beat_d == BEAT_LAST);
    ready_d    = !(out_valid_d && skid_valid_d);
  end

  // State registers; a synchronous reset clears the buffer and both counters.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
      beat_q       <= '0;
      frame_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
      beat_q       <= beat_d;
      frame_q      <= frame_d;
    end
  end

endmodule

// File: tb/tb_lrf_dummy_stream.sv
// Bench for lrf_dummy_stream. A queue-based reference model checks the order
// and content of the output beats. The expected framing and frame tag come from
// the count of output handshakes.
module tb_lrf_dummy_stream;
  localparam int PPB = 16;
  localparam int DIM = 16;
  localparam int NF  = 4;
  localparam int WPF = DIM * DIM / PPB;
  localparam int DW  = 8 * PPB;
`ifdef LRF_DUMMY_FRAME_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;

  always #5 clk = ~clk;

  lrf_dummy_stream #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .N_FUSE_COUNT(NF)) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: beats accepted by the DUT, in order.
  logic [DW-1:0] q[$];
  int            in_total = 0, out_total = 0, tlast_cnt = 0, out_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW-1:0] exp_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      out_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1'b1);
        chk("hold_data", m_tdata, prev_data);
        chk("hold_last", m_tlast, prev_last);
      end
      if (m_tvalid) begin
        chk("beat_pending", (q.size() > 0), 1'b1);
        if (q.size() > 0) begin
          exp_beat = q[0];
          if (TAG && (out_cnt % WPF) == 0) exp_beat[DW-1 -: 8] = 8'((out_cnt / WPF) % NF);
          chk("data", m_tdata, exp_beat);
          chk("last", m_tlast, (out_cnt % WPF) == WPF - 1);
        end
        if (m_tready) begin
          if (q.size() > 0) void'(q.pop_front());
          out_cnt++;
          out_total++;
          if (m_tlast) tlast_cnt++;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (s_tvalid && s_tready) begin
        q.push_back(s_tdata);
        in_total++;
      end
    end
  end

  int            mode = 0;
  int            base = 0;
  logic [DW-1:0] rnd[256];

  function automatic logic [DW-1:0] gen(input int idx);
    case (mode)
      0:       gen = {PPB{8'(idx)}};
      1:       gen = rnd[idx % 256];
      default: gen = '1;
    endcase
  endfunction

  // Source data depends only on how many beats have been accepted, so it stays stable while stalled.
  task automatic tick();
    @(posedge clk);
    #1;
    s_tdata = gen(in_total - base);
    s_tlast = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int out0, in0, last0, prev;
    for (int i = 0; i < 256; i++) rnd[i] = {$urandom, $urandom, $urandom, $urandom};
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;

    // Reset state, then ready one cycle after release.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_m_valid", m_tvalid, 1'b0);
      chk("rst_m_last", m_tlast, 1'b0);
      chk("rst_m_data", m_tdata, '0);
      chk("rst_s_ready", s_tready, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_s_ready", s_tready, 1'b1);
    chk("rel_m_valid", m_tvalid, 1'b0);
    tick();
    chk("idle_m_valid", m_tvalid, 1'b0);

    // Full throughput over 3 frames: one-cycle latency, no gaps.
    mode     = 0;
    base     = in_total;
    out0     = out_total;
    last0    = tlast_cnt;
    m_tready = 1'b1;
    s_tdata  = gen(0);
    s_tvalid = 1'b1;
    for (int n = 0; n < 48; n++) begin
      prev = in_total;
      tick();
      chk("ff_accept", in_total - prev, 1);
      chk("ff_valid", m_tvalid, 1'b1);
      chk("ff_byte", m_tdata[7:0], 8'(n));
      chk("ff_last", m_tlast, (n % 16) == 15);
      if (n == 47) s_tvalid = 1'b0;
    end
    tick();
    chk("ff_total", out_total - out0, 48);
    chk("ff_tlasts", tlast_cnt - last0, 3);

    // Random valid/ready over 4 frames.
    mode  = 1;
    base  = in_total;
    out0  = out_total;
    last0 = tlast_cnt;
    for (int cyc = 0; cyc < 3000 && (out_total - out0) < 64; cyc++) begin
      prev = in_total;
      tick();
      if (!s_tvalid || in_total != prev)
        s_tvalid = (in_total - base < 64) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_tready = 1'($urandom_range(0, 1));
    end
    chk("rand_total", out_total - out0, 64);
    chk("rand_tlasts", tlast_cnt - last0, 4);
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    tick();
    tick();

    // Downstream stall: two beats buffered, then three drain back to back.
    mode     = 0;
    base     = in_total;
    in0      = in_total;
    m_tready = 1'b0;
    s_tdata  = gen(0);
    s_tvalid = 1'b1;
    repeat (10) tick();
    chk("stall_ready", s_tready, 1'b0);
    chk("stall_count", in_total - in0, 2);
    chk("stall_valid", m_tvalid, 1'b1);
    m_tready = 1'b1;
    out0     = out_total;
    for (int i = 0; i < 3; i++) begin
      chk("drain_valid", m_tvalid, 1'b1);
      tick();
      if (in_total - base >= 3) s_tvalid = 1'b0;
    end
    chk("drain_count", out_total - out0, 3);
    chk("drain_idle", m_tvalid, 1'b0);

    // Reset at beat 7 of frame 1; the next frame restarts at beat 0.
    do_reset();
    base     = in_total;
    out0     = out_total;
    s_tdata  = gen(0);
    s_tvalid = 1'b1;
    for (int cyc = 0; cyc < 200 && (out_total - out0) < 23; cyc++) tick();
    chk("mid_reach", out_total - out0, 23);
    rst_n = 1'b0;
    tick();
    chk("mid_m_valid", m_tvalid, 1'b0);
    chk("mid_m_last", m_tlast, 1'b0);
    chk("mid_m_data", m_tdata, '0);
    chk("mid_s_ready", s_tready, 1'b0);
    rst_n = 1'b1;
    tick();
    base     = in_total;
    out0     = out_total;
    last0    = tlast_cnt;
    s_tdata  = gen(0);
    s_tvalid = 1'b1;
    for (int cyc = 0; cyc < 200 && (out_total - out0) < 16; cyc++) begin
      tick();
      if (in_total - base >= 16) s_tvalid = 1'b0;
      if (m_tvalid) chk("post_last", m_tlast, (out_total - out0) == 15);
    end
    chk("post_total", out_total - out0, 16);
    chk("post_tlasts", tlast_cnt - last0, 1);

    // Five frames of 0xFF: the MSB byte of beat 0 carries the frame index when tagging is enabled.
    do_reset();
    mode     = 2;
    base     = in_total;
    out0     = out_total;
    s_tdata  = gen(0);
    s_tvalid = 1'b1;
    for (int cyc = 0; cyc < 400 && (out_total - out0) < 80; cyc++) begin
      tick();
      if (in_total - base >= 80) s_tvalid = 1'b0;
      if (m_tvalid && ((out_total - out0) % 16) == 0) begin
        chk("tag_msb", m_tdata[DW-1 -: 8], TAG ? 8'(((out_total - out0) / 16) % NF) : 8'hFF);
        chk("tag_rest", m_tdata[DW-9:0], {(DW-8){1'b1}});
      end
    end
    chk("tag_total", out_total - out0, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
